// File: rtl/ahb_lite_bus_arbiter_pkg.sv
// Shared AHB-Lite definitions for the multi-master bus arbiter.
// Bus widths, transfer/burst/response encodings and the burst-length helper.
package ahb_lite_bus_arbiter_pkg;

    localparam int ADDRWIDTH        = 32;
    localparam int DATAWIDTH        = 32;
    localparam int DATATRANFER_SIZE = 3;
    localparam int NUM_MASTERS_MAX  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } Trans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } BType_t;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } Response_t;

    // Undefined-length bursts (SINGLE, INCR) report zero so they never hold the bus.
    function automatic logic [4:0] burst_beats(BType_t burst);
        case (burst)
            WRAP4, INCR4:   return 5'd4;
            WRAP8, INCR8:   return 5'd8;
            WRAP16, INCR16: return 5'd16;
            default:        return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_bus_arbiter_if.sv
// Master-side request bundle and shared-bus outputs of the AHB-Lite arbiter.
// The arbiter sits on the slave modport; the masters (or a bench) use the master modport.
interface ahb_lite_bus_arbiter_if
    import ahb_lite_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2
);

    logic [NUM_MASTERS-1:0]                  HBUSREQ;
    logic [NUM_MASTERS-1:0]                  HLOCK;
    logic [NUM_MASTERS*ADDRWIDTH-1:0]        M_HADDR;
    logic [NUM_MASTERS*2-1:0]                M_HTRANS;
    logic [NUM_MASTERS-1:0]                  M_HWRITE;
    logic [NUM_MASTERS*DATATRANFER_SIZE-1:0] M_HSIZE;
    logic [NUM_MASTERS*3-1:0]                M_HBURST;
    logic [NUM_MASTERS*4-1:0]                M_HPROT;
    logic [NUM_MASTERS*DATAWIDTH-1:0]        M_HWDATA;
    logic                                    HREADY;

    logic [NUM_MASTERS-1:0]                  HGRANT;
    logic [1:0]                              HMASTER;
    logic [ADDRWIDTH-1:0]                    HADDR;
    logic [1:0]                              HTRANS;
    logic                                    HWRITE;
    logic [DATATRANFER_SIZE-1:0]             HSIZE;
    logic [2:0]                              HBURST;
    logic [3:0]                              HPROT;
    logic                                    HMASTLOCK;
    logic [DATAWIDTH-1:0]                    HWDATA;

    modport master (
        output HBUSREQ, HLOCK, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE,
               M_HBURST, M_HPROT, M_HWDATA, HREADY,
        input  HGRANT, HMASTER, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
               HPROT, HMASTLOCK, HWDATA
    );

    modport slave (
        input  HBUSREQ, HLOCK, M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE,
               M_HBURST, M_HPROT, M_HWDATA, HREADY,
        output HGRANT, HMASTER, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
               HPROT, HMASTLOCK, HWDATA
    );

endinterface

// File: rtl/ahb_lite_bus_arbiter_rr_pick.sv
// Round-robin winner search: first requester scanning circularly from last+1.
// The last owner is considered only after every other master, so it wins only when alone.
module ahb_rr_pick #(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             last,
    output logic [1:0]             next,
    output logic                   valid
);

    logic cand_hit_s;

    // Scan farthest-first so the nearest requester after 'last' is written last and wins.
    always_comb begin
        next       = last;
        valid      = 1'b0;
        cand_hit_s = 1'b0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                cand_hit_s = req[j] && (((int'(last) + k) % NUM_MASTERS) == j);
                next       = cand_hit_s ? 2'(j) : next;
                valid      = valid | cand_hit_s;
            end
        end
    end

endmodule

// File: rtl/ahb_lite_bus_arbiter.sv
// Round-robin AHB-Lite arbiter: grants the shared address bus at burst boundaries,
// honours HLOCK, and steers HWDATA from the master owning the current data phase.
module ahb_lite_bus_arbiter
    import ahb_lite_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    ahb_lite_bus_arbiter_if.slave  bus
);

    logic [1:0]                  owner_r;
    logic [1:0]                  downer_r;
    logic [4:0]                  beats_r;

    logic [4:0]                  beats_next_s;
    logic [4:0]                  burst_len_s;
    logic                        arb_point_s;
    logic [1:0]                  pick_idx_s;
    logic                        pick_valid_s;

    logic [ADDRWIDTH-1:0]        sel_addr_s;
    logic [1:0]                  sel_trans_s;
    logic                        sel_write_s;
    logic [DATATRANFER_SIZE-1:0] sel_size_s;
    logic [2:0]                  sel_burst_s;
    logic [3:0]                  sel_prot_s;
    logic                        sel_lock_s;
    logic                        sel_req_s;
    logic [DATAWIDTH-1:0]        sel_wdata_s;
    Trans_t                      owner_trans_s;
    BType_t                      owner_burst_s;

    // AND-OR select of the address-phase owner's fields and the data-phase owner's write data.
    always_comb begin
        sel_addr_s  = '0;
        sel_trans_s = '0;
        sel_write_s = 1'b0;
        sel_size_s  = '0;
        sel_burst_s = '0;
        sel_prot_s  = '0;
        sel_lock_s  = 1'b0;
        sel_req_s   = 1'b0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sel_addr_s  |= bus.M_HADDR[i*ADDRWIDTH +: ADDRWIDTH] & {ADDRWIDTH{owner_r == 2'(i)}};
            sel_trans_s |= bus.M_HTRANS[i*2 +: 2] & {2{owner_r == 2'(i)}};
            sel_write_s |= bus.M_HWRITE[i] & (owner_r == 2'(i));
            sel_size_s  |= bus.M_HSIZE[i*DATATRANFER_SIZE +: DATATRANFER_SIZE]
                           & {DATATRANFER_SIZE{owner_r == 2'(i)}};
            sel_burst_s |= bus.M_HBURST[i*3 +: 3] & {3{owner_r == 2'(i)}};
            sel_prot_s  |= bus.M_HPROT[i*4 +: 4] & {4{owner_r == 2'(i)}};
            sel_lock_s  |= bus.HLOCK[i] & (owner_r == 2'(i));
            sel_req_s   |= bus.HBUSREQ[i] & (owner_r == 2'(i));
            sel_wdata_s |= bus.M_HWDATA[i*DATAWIDTH +: DATAWIDTH] & {DATAWIDTH{downer_r == 2'(i)}};
        end
        owner_trans_s = Trans_t'(sel_trans_s);
        owner_burst_s = BType_t'(sel_burst_s);
    end

    // Remaining-beat bookkeeping; only beats the slave accepts move the counter.
    always_comb begin
        burst_len_s  = burst_beats(owner_burst_s);
        beats_next_s = beats_r;
        if (bus.HREADY) begin
            case (owner_trans_s)
                NONSEQ:  beats_next_s = (burst_len_s == 5'd0) ? 5'd0 : burst_len_s - 5'd1;
                SEQ:     beats_next_s = (beats_r != 5'd0) ? beats_r - 5'd1 : 5'd0;
                IDLE:    beats_next_s = 5'd0;
                default: beats_next_s = beats_r;
            endcase
        end else begin
            beats_next_s = beats_r;
        end
    end

    // An INCR burst keeps the bus while its master still requests and is transferring.
    always_comb begin
        arb_point_s = bus.HREADY
                      && !sel_lock_s
                      && (beats_next_s == 5'd0)
                      && (owner_trans_s != BUSY)
                      && ((owner_burst_s != INCR) || (owner_trans_s == IDLE) || !sel_req_s);
    end

    ahb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_pick (
        .req   (bus.HBUSREQ),
        .last  (owner_r),
        .next  (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Owner, data-phase owner and beat counter; master 0 is parked out of reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner_r  <= 2'd0;
            downer_r <= 2'd0;
            beats_r  <= 5'd0;
        end else begin
            beats_r <= beats_next_s;
            if (bus.HREADY) begin
                downer_r <= owner_r;
            end
            if (arb_point_s && pick_valid_s) begin
                owner_r <= pick_idx_s;
            end
        end
    end

    // Shared-bus drive; HTRANS is held at IDLE while reset is asserted.
    always_comb begin
        bus.HGRANT = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus.HGRANT[i] = (owner_r == 2'(i));
        end
        bus.HMASTER   = owner_r;
        bus.HADDR     = sel_addr_s;
        bus.HTRANS    = HRESET ? IDLE : owner_trans_s;
        bus.HWRITE    = sel_write_s;
        bus.HSIZE     = sel_size_s;
        bus.HBURST    = sel_burst_s;
        bus.HPROT     = sel_prot_s;
        bus.HMASTLOCK = sel_lock_s;
        bus.HWDATA    = sel_wdata_s;
    end

endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// Directed scenarios followed by random traffic, every cycle compared against a
// transaction-level reference of ownership, burst length and data-phase ownership.
module tb_ahb_lite_bus_arbiter;
    import ahb_lite_bus_arbiter_pkg::*;

    localparam int NM = 2;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks;
    int   errors;
    int   m_owner;
    int   m_downer;
    int   m_beats;

    ahb_lite_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

    ahb_lite_bus_arbiter #(.NUM_MASTERS(NM)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic [1:0] t, input logic [2:0] b,
                         input logic [31:0] a, input logic [31:0] d, input bit rq, input bit lk);
        bus.M_HTRANS[m*2 +: 2]  = t;
        bus.M_HBURST[m*3 +: 3]  = b;
        bus.M_HADDR[m*32 +: 32] = a;
        bus.M_HWDATA[m*32 +: 32] = d;
        bus.M_HWRITE[m]         = 1'b1;
        bus.M_HSIZE[m*3 +: 3]   = 3'b010;
        bus.M_HPROT[m*4 +: 4]   = 4'b0011;
        bus.HBUSREQ[m]          = rq;
        bus.HLOCK[m]            = lk;
    endtask

    function automatic logic [1:0] trans_of(input int m);
        return bus.M_HTRANS[m*2 +: 2];
    endfunction

    function automatic logic [2:0] burst_of(input int m);
        return bus.M_HBURST[m*3 +: 3];
    endfunction

    // Reference: ownership moves only at burst ends, circular search from owner+1.
    task automatic model_step();
        int t;
        int hb;
        int len;
        int nb;
        bit arb;
        bit found;
        if (HRESET) begin
            m_owner  = 0;
            m_downer = 0;
            m_beats  = 0;
            return;
        end
        t   = int'(trans_of(m_owner));
        hb  = int'(burst_of(m_owner));
        len = (hb >= 2) ? (4 << ((hb - 2) / 2)) : 0;
        nb  = m_beats;
        if (bus.HREADY) begin
            if (t == 2)                     nb = (len > 0) ? len - 1 : 0;
            else if (t == 3 && m_beats > 0) nb = m_beats - 1;
            else if (t == 0)                nb = 0;
        end
        arb = bus.HREADY && !bus.HLOCK[m_owner] && nb == 0 && t != 1
              && (hb != 1 || t == 0 || !bus.HBUSREQ[m_owner]);
        if (bus.HREADY) m_downer = m_owner;
        found = 1'b0;
        if (arb) begin
            for (int k = 1; k <= NM; k++) begin
                if (!found && bus.HBUSREQ[(m_owner + k) % NM]) begin
                    m_owner = (m_owner + k) % NM;
                    found   = 1'b1;
                end
            end
        end
        m_beats = nb;
    endtask

    task automatic check_outputs();
        chk("hgrant",    bus.HGRANT, 64'(1) << m_owner);
        chk("hmaster",   bus.HMASTER, 64'(m_owner));
        chk("htrans",    bus.HTRANS, HRESET ? 64'd0 : 64'(trans_of(m_owner)));
        chk("haddr",     bus.HADDR, 64'(bus.M_HADDR[m_owner*32 +: 32]));
        chk("hctrl",     {bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT},
                         {bus.M_HWRITE[m_owner], bus.M_HSIZE[m_owner*3 +: 3],
                          bus.M_HBURST[m_owner*3 +: 3], bus.M_HPROT[m_owner*4 +: 4]});
        chk("hmastlock", bus.HMASTLOCK, 64'(bus.HLOCK[m_owner]));
        chk("hwdata",    bus.HWDATA, 64'(bus.M_HWDATA[m_downer*32 +: 32]));
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_owner = 0; m_downer = 0; m_beats = 0;
        HRESET = 1'b1;
        bus.HREADY = 1'b1;
        bus.HBUSREQ = '0; bus.HLOCK = '0; bus.M_HADDR = '0; bus.M_HTRANS = '0;
        bus.M_HWRITE = '0; bus.M_HSIZE = '0; bus.M_HBURST = '0; bus.M_HPROT = '0;
        bus.M_HWDATA = '0;

        // Reset with both masters requesting; HTRANS forced IDLE.
        drive(0, NONSEQ, SINGLE, 32'h000, 32'h11, 1'b1, 1'b0);
        drive(1, NONSEQ, SINGLE, 32'h100, 32'h22, 1'b1, 1'b0);
        @(posedge HCLK); #1;
        chk("rst_grant", bus.HGRANT, 64'h1);
        chk("rst_hmaster", bus.HMASTER, 64'h0);
        chk("rst_htrans", bus.HTRANS, 64'(IDLE));
        cycle();
        HRESET = 1'b0;
        drive(0, IDLE, SINGLE, 32'h000, 32'h11, 1'b1, 1'b0);
        drive(1, IDLE, SINGLE, 32'h100, 32'h22, 1'b1, 1'b0);
        chk("post_rst_owner", bus.HGRANT, 64'h1);
        cycle();
        chk("first_arb", bus.HGRANT, 64'h2);
        drive(1, IDLE, SINGLE, 32'h100, 32'h22, 1'b0, 1'b0);
        cycle();
        chk("park_m0", bus.HGRANT, 64'h1);

        // INCR4 from M0 is not broken by M1 requesting on beat 2.
        drive(0, NONSEQ, INCR4, 32'h010, 32'hD000, 1'b1, 1'b0);
        cycle();
        for (int b = 1; b < 4; b++) begin
            drive(0, SEQ, INCR4, 32'h010 + 32'(4*b), 32'hD000 + 32'(b), 1'b1, 1'b0);
            drive(1, IDLE, SINGLE, 32'h100, 32'h22, 1'b1, 1'b0);
            chk("burst_hold", bus.HGRANT, 64'h1);
            cycle();
        end
        chk("burst_handover", bus.HGRANT, 64'h2);
        drive(0, IDLE, SINGLE, 32'h000, 32'hD004, 1'b0, 1'b0);
        drive(1, NONSEQ, SINGLE, 32'h104, 32'hE000, 1'b1, 1'b0);
        #1 chk("hwdata_m0_tail", bus.HWDATA, 64'hD004);
        cycle();
        drive(1, IDLE, SINGLE, 32'h104, 32'hE001, 1'b1, 1'b0);
        #1 chk("hwdata_m1", bus.HWDATA, 64'hE001);
        cycle();

        // WRAP4 from M1 with three wait states on its last beat.
        drive(1, NONSEQ, WRAP4, 32'h120, 32'hE010, 1'b1, 1'b0);
        cycle();
        drive(1, SEQ, WRAP4, 32'h124, 32'hE011, 1'b1, 1'b0);
        cycle();
        drive(1, SEQ, WRAP4, 32'h128, 32'hE012, 1'b1, 1'b0);
        cycle();
        drive(1, SEQ, WRAP4, 32'h12C, 32'hE013, 1'b1, 1'b0);
        drive(0, IDLE, SINGLE, 32'h000, 32'hD00F, 1'b1, 1'b0);
        bus.HREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
            chk("wait_hold", bus.HGRANT, 64'h2);
            cycle();
        end
        bus.HREADY = 1'b1;
        chk("wait_hold_last", bus.HGRANT, 64'h2);
        cycle();
        chk("wait_switch", bus.HGRANT, 64'h1);
        drive(0, NONSEQ, SINGLE, 32'h020, 32'hD010, 1'b1, 1'b0);
        drive(1, IDLE, SINGLE, 32'h12C, 32'hE014, 1'b0, 1'b0);
        bus.HREADY = 1'b0;
        #1 chk("downer_hold", bus.HWDATA, 64'hE014);
        cycle();
        #1 chk("downer_hold2", bus.HWDATA, 64'hE014);
        bus.HREADY = 1'b1;
        cycle();
        #1 chk("downer_move", bus.HWDATA, 64'hD010);

        // Locked SINGLEs from M1 while M0 keeps requesting.
        drive(0, IDLE, SINGLE, 32'h000, 32'hD010, 1'b0, 1'b0);
        drive(1, IDLE, SINGLE, 32'h104, 32'hE020, 1'b1, 1'b1);
        cycle();
        chk("lock_owner", bus.HGRANT, 64'h2);
        for (int n = 0; n < 2; n++) begin
            drive(1, NONSEQ, SINGLE, 32'h104, 32'hE021 + 32'(n), 1'b1, 1'b1);
            drive(0, IDLE, SINGLE, 32'h000, 32'hD011, 1'b1, 1'b0);
            #1 chk("lock_mastlock", bus.HMASTLOCK, 64'h1);
            cycle();
            chk("lock_keep", bus.HGRANT, 64'h2);
        end
        drive(1, IDLE, SINGLE, 32'h104, 32'hE023, 1'b0, 1'b0);
        #1 chk("lock_dropped", bus.HMASTLOCK, 64'h0);
        cycle();
        chk("lock_release", bus.HGRANT, 64'h1);

        // Back-to-back SINGLEs from both masters alternate strictly.
        for (int i = 0; i < 8; i++) begin
            drive(0, NONSEQ, SINGLE, 32'h200 + 32'(4*i), 32'hA000 + 32'(i), 1'b1, 1'b0);
            drive(1, NONSEQ, SINGLE, 32'h300 + 32'(4*i), 32'hB000 + 32'(i), 1'b1, 1'b0);
            chk("rr_seq", bus.HMASTER, 64'(i % 2));
            cycle();
        end

        // Reset asserted on beat 3 of an M1 INCR8.
        drive(0, IDLE, SINGLE, 32'h000, 32'hA100, 1'b0, 1'b0);
        drive(1, IDLE, INCR8, 32'h140, 32'hB100, 1'b1, 1'b0);
        cycle();
        chk("midrst_owner_m1", bus.HGRANT, 64'h2);
        drive(1, NONSEQ, INCR8, 32'h140, 32'hB101, 1'b1, 1'b0);
        cycle();
        drive(1, SEQ, INCR8, 32'h144, 32'hB102, 1'b1, 1'b0);
        cycle();
        drive(1, SEQ, INCR8, 32'h148, 32'hB103, 1'b1, 1'b0);
        HRESET = 1'b1;
        cycle();
        chk("midrst_grant", bus.HGRANT, 64'h1);
        chk("midrst_hmaster", bus.HMASTER, 64'h0);
        #1 chk("midrst_htrans", bus.HTRANS, 64'(IDLE));
        HRESET = 1'b0;
        drive(0, SEQ, SINGLE, 32'h000, 32'hA101, 1'b0, 1'b0);
        cycle();
        chk("midrst_beats_clear", bus.HGRANT, 64'h2);

        // Random traffic against the reference.
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < NM; m++) begin
                drive(m, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
                bus.M_HWRITE[m]       = 1'($urandom_range(0, 1));
                bus.M_HPROT[m*4 +: 4] = 4'($urandom_range(0, 15));
            end
            bus.HREADY = ($urandom_range(0, 3) != 0);
            HRESET     = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_bus_arbiter.md
Name: ahb_lite_bus_arbiter

Overview:
- Shares the single AHB-Lite slave subsystem (decoder + two memController slaves + response mux) between NUM_MASTERS bus masters.
- Arbitrates round-robin at burst boundaries and honours HMASTLOCK.
- Drives the shared address/control bus from the address-phase owner and HWDATA from the data-phase owner.
- Sits between the masters and the slave subsystem top. HRDATA, HRESP and HREADY are broadcast to all masters directly, not through this block.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- ADDRWIDTH, package value, address width.
- DATAWIDTH, package value, data width.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  synchronous, active-high reset.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- M_HADDR  in  NUM_MASTERS*ADDRWIDTH  packed per-master address.
- M_HTRANS  in  NUM_MASTERS*2  packed Trans_t.
- M_HWRITE  in  NUM_MASTERS  per-master write.
- M_HSIZE  in  NUM_MASTERS*DATATRANFER_SIZE  packed size.
- M_HBURST  in  NUM_MASTERS*3  packed BType_t.
- M_HPROT  in  NUM_MASTERS*4  packed protection.
- M_HWDATA  in  NUM_MASTERS*DATAWIDTH  packed write data.
- HREADY  in  1  combined ready from the slave-side mux.
- HGRANT  out  NUM_MASTERS  one-hot address-phase grant.
- HMASTER  out  2  index of the address-phase owner.
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT  out  bus widths  muxed from the owner.
- HMASTLOCK  out  1  HLOCK of the owner.
- HWDATA  out  DATAWIDTH  muxed from the data-phase owner.

Behaviour:
- Registers:
  - owner: address-phase owner index.
  - downer: data-phase owner index.
  - beats: remaining-beat counter, 5 bits.
- Reset (HRESET=1 at posedge):
  - owner=0, downer=0, beats=0, HGRANT=1 (master 0 parked).
  - While HRESET is high, output HTRANS is forced to IDLE. All other outputs are combinational muxes of the registers.
- Beat tracking, only on an accepted beat (HREADY=1 and owner HTRANS is NONSEQ or SEQ):
  - On NONSEQ, beats is loaded with len-1. len = 4/8/16 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16, and len = 0 (beats=0) for SINGLE and INCR.
  - On SEQ with beats>0, beats decrements.
  - Owner HTRANS=IDLE at HREADY=1 clears beats. This covers an early-terminated burst after an ERROR.
- Arbitration point, evaluated at posedge with all of:
  - HREADY=1 and HLOCK[owner]=0.
  - beats==0 after the update above. Any pending fixed burst blocks the switch.
  - Owner HTRANS is not BUSY.
  - For INCR bursts: owner HTRANS is IDLE or HBUSREQ[owner]=0.
- Winner selection at an arbitration point:
  - The winner is the first requesting master scanning circularly from owner+1.
  - If no master requests, owner is kept (parking).
  - If only the owner requests, owner is kept.
  - owner/HGRANT update at that edge. The new owner's first address phase is the following cycle.
- Data-phase tracking: at every posedge with HREADY=1, downer <= owner. When HREADY=0, downer holds and HWDATA stays on the stalled beat's master.
- Locked transfers: while HLOCK[owner]=1, no re-arbitration occurs, regardless of other requests or beats.
- HREADY=0 at a would-be arbitration point: no change. Arbitration retries on the next HREADY=1 cycle.
- Simultaneous requests from all masters: strict round-robin. With 2 masters, grants alternate 0,1,0,1 at successive arbitration points.
- Reset mid-burst: registers return to reset values on the next edge. No partial-burst state survives.

Decomposition:
- Definitions package additions:
  - Constant NUM_MASTERS_MAX=4.
  - Function burst_beats(BType_t) returning the 5-bit length.
  - Reuses the existing Trans_t, BType_t and Response_t.
- One sub-module, ahb_rr_pick: combinational; inputs req vector and last owner; outputs next index and a valid flag.
- Top: beat counter, owner/downer registers, output muxes.

Test Plan:
- Reset:
  - Stimulus: hold HRESET=1 two cycles with HBUSREQ=2'b11.
  - Required response: HGRANT=01, HMASTER=0, HTRANS=IDLE; after release, master 0 remains owner until its first arbitration point.
- Fixed burst not broken:
  - Stimulus: M0 INCR4 write to 0x010 with HREADY=1; M1 requests on beat 2.
  - Required response: HGRANT stays 01 for all 4 beats. HGRANT=10 on the edge after the 4th beat is accepted. HWDATA carries M0 data for one more cycle, then M1.
- Wait states:
  - Stimulus: HREADY=0 for 3 cycles during the last beat of a WRAP4.
  - Required response: no grant change and downer held; HGRANT switches only after the edge where HREADY=1.
- Locked transfer:
  - Stimulus: M1 owner with HLOCK=1, two SINGLE transfers to 0x104, M0 requesting throughout.
  - Required response: M1 keeps the grant for both transfers. HMASTLOCK=1 on both. M0 is granted on the first arbitration point after HLOCK drops.
- Round-robin fairness:
  - Stimulus: both masters issue back-to-back SINGLEs continuously.
  - Required response: HMASTER sequence 0,1,0,1 over 8 transfers; no master granted twice in a row.
- Reset mid-operation:
  - Stimulus: HRESET asserted during beat 3 of an M1 INCR8.
  - Required response: the next edge gives owner=0, beats=0, HTRANS=IDLE.
